imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the RISC-V pipeline. It accepts raw 32-bit instruction words over a valid/ready handshake and decodes the immediate for every base format (I, S, B, U, J and shift-amount). It sign- or zero-extends the immediate to XLEN and delivers it, with its format code and a passthrough tag, through a DEPTH-entry in-order buffer. It sits between fetch/decode and the ID/EX register, replacing the purely combinational generator, and adds backpressure, flush and RV64 support.

---
 rtl/imm_gen_stage_pkg.sv | 25 ++
 rtl/imm_gen_stage_if.sv | 27 ++
 rtl/imm_gen_stage_decode.sv | 69 ++++++
 rtl/imm_gen_stage.sv | 82 ++++++++
 tb/tb_imm_gen_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
package imm_pkg;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      I    = 3'd1,
      S    = 3'd2,
      B    = 3'd3,
      U    = 3'd4,
      J    = 3'd5,
      SH   = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Producer/consumer handshake bundle for imm_gen_stage.
interface imm_gen_stage_if
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   imm_fmt_e         out_fmt;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_inst, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_tag
   );

   modport slave (
      input  in_valid, in_inst, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_tag
   );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decoder: instruction word -> {imm, fmt}.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_i,
   output logic [XLEN-1:0] imm_o,
   output imm_fmt_e        fmt_o
);
   localparam logic RV64 = (XLEN == 64);

   logic is_shift;
   assign is_shift = (inst_i[14:12] == 3'b001) || (inst_i[14:12] == 3'b101);

   always_comb begin
      imm_o = '0;
      fmt_o = NONE;
      case (inst_i[6:0])
         OP_LOAD, OP_JALR, OP_SYSTEM: begin
            imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
            fmt_o = I;
         end
         OP_IMM: begin
            if (is_shift) begin
               // shamt grows to 6 bits only on RV64
               imm_o = {{(XLEN-6){1'b0}}, inst_i[25] & RV64, inst_i[24:20]};
               fmt_o = SH;
            end else begin
               imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
               fmt_o = I;
            end
         end
         OP_IMM32: begin
            if (RV64) begin
               if (is_shift) begin
                  imm_o = {{(XLEN-5){1'b0}}, inst_i[24:20]};
                  fmt_o = SH;
               end else begin
                  imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
                  fmt_o = I;
               end
            end
         end
         OP_STORE: begin
            imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            fmt_o = S;
         end
         OP_BRANCH: begin
            imm_o = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                     inst_i[30:25], inst_i[11:8], 1'b0};
            fmt_o = B;
         end
         OP_LUI, OP_AUIPC: begin
            imm_o = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
            fmt_o = U;
         end
         OP_JAL: begin
            imm_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                     inst_i[20], inst_i[30:21], 1'b0};
            fmt_o = J;
         end
         default: begin
            imm_o = '0;
            fmt_o = NONE;
         end
      endcase
   end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode on push into a DEPTH-entry
// in-order buffer with valid/ready handshake and flush.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   imm_gen_stage_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0]  imm_q [DEPTH];
   imm_fmt_e         fmt_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   logic            push, pop;

   imm_decode #(.XLEN(XLEN)) u_dec (
      .inst_i (bus.in_inst),
      .imm_o  (dec_imm),
      .fmt_o  (dec_fmt)
   );

   // Ready depends only on registered occupancy, never on out_ready.
   assign bus.in_ready  = !reset && (cnt_q < CW'(DEPTH));
   assign bus.out_valid = !reset && (cnt_q != '0);
   assign bus.out_imm   = imm_q[rd_ptr_q];
   assign bus.out_fmt   = fmt_q[rd_ptr_q];
   assign bus.out_tag   = tag_q[rd_ptr_q];

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      cnt_d = cnt_q + CW'(1);
         else if (pop && !push) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            imm_q[i] <= '0;
            fmt_q[i] <= NONE;
            tag_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push && !flush) begin
            imm_q[wr_ptr_q] <= dec_imm;
            fmt_q[wr_ptr_q] <= dec_fmt;
            tag_q[wr_ptr_q] <= bus.in_tag;
         end
      end
   end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench: RV32 and RV64 instances driven in lockstep and checked
// against an arithmetic reference decoder.
module tb_imm_gen_stage;
   import imm_pkg::*;

   localparam int DEPTH = 2;
   localparam int TAG_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [31:0]      in_inst = '0;
   logic [TAG_W-1:0] in_tag = '0;

   always #5 clk = ~clk;

   imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

   assign b32.in_valid = in_valid;  assign b64.in_valid = in_valid;
   assign b32.in_inst  = in_inst;   assign b64.in_inst  = in_inst;
   assign b32.in_tag   = in_tag;    assign b64.in_tag   = in_tag;
   assign b32.out_ready = out_ready; assign b64.out_ready = out_ready;

   imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b32.slave));
   imm_gen_stage #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .reset(reset), .flush(flush), .bus(b64.slave));

   typedef struct {
      logic [63:0]      imm;
      logic [2:0]       fmt;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   tests = 0;
   int   fails = 0;
   int   n_acc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Two's-complement interpretation of an n-bit field.
   function automatic longint sx(input longint f, input int n);
      return (f >= (longint'(1) << (n - 1))) ? f - (longint'(1) << n) : f;
   endfunction

   function automatic exp_t ref_dec(input logic [31:0] w, input bit rv64,
                                    input logic [TAG_W-1:0] tag);
      exp_t   e;
      longint v = 0;
      int     code = 0;
      bit     sh = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
      case (w[6:0])
         7'h03, 7'h67, 7'h73: begin v = sx(longint'(w[31:20]), 12); code = 1; end
         7'h13: begin
            if (sh) begin v = rv64 ? longint'(w[25:20]) : longint'(w[24:20]); code = 6; end
            else    begin v = sx(longint'(w[31:20]), 12); code = 1; end
         end
         7'h1B: begin
            if (rv64 && sh)  begin v = longint'(w[24:20]); code = 6; end
            else if (rv64)   begin v = sx(longint'(w[31:20]), 12); code = 1; end
         end
         7'h23: begin v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12); code = 2; end
         7'h63: begin
            v = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                   longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
            code = 3;
         end
         7'h37, 7'h17: begin v = sx(longint'(w[31:12]) * 4096, 32); code = 4; end
         7'h6F: begin
            v = sx(longint'(w[31]) * (1 << 20) + longint'(w[19:12]) * 4096 +
                   longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
            code = 5;
         end
         default: begin v = 0; code = 0; end
      endcase
      e.imm = rv64 ? 64'(v) : {32'b0, 32'(v)};
      e.fmt = 3'(code);
      e.tag = tag;
      return e;
   endfunction

   // Scoreboard push side: record accepted entries, clear on flush/reset.
   always @(negedge clk) begin
      #1;
      if (reset || flush) begin
         q32.delete();
         q64.delete();
      end else if (in_valid && b32.in_ready) begin
         q32.push_back(ref_dec(in_inst, 1'b0, in_tag));
         q64.push_back(ref_dec(in_inst, 1'b1, in_tag));
         n_acc++;
      end
   end

   // Monitor: compare head against scoreboard whenever the DUT presents one.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         chk("valid32", 64'(b32.out_valid), 64'(q32.size() != 0));
         chk("valid64", 64'(b64.out_valid), 64'(q64.size() != 0));
      end
      if (b32.out_valid && q32.size() != 0) begin
         e = q32[0];
         chk("imm32", {32'b0, b32.out_imm}, e.imm);
         chk("fmt32", 64'(b32.out_fmt), 64'(e.fmt));
         chk("tag32", 64'(b32.out_tag), 64'(e.tag));
         if (out_ready && !flush) void'(q32.pop_front());
      end
      if (b64.out_valid && q64.size() != 0) begin
         e = q64[0];
         chk("imm64", b64.out_imm, e.imm);
         chk("fmt64", 64'(b64.out_fmt), 64'(e.fmt));
         chk("tag64", 64'(b64.out_tag), 64'(e.tag));
         if (out_ready && !flush) void'(q64.pop_front());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input logic [31:0] w, input logic [31:0] e32,
                           input logic [63:0] e64, input logic [2:0] f32,
                           input logic [2:0] f64, input logic [TAG_W-1:0] t);
      cyc(); in_valid = 1'b1; in_inst = w; in_tag = t; out_ready = 1'b0;
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      chk("dir_valid32", 64'(b32.out_valid), 64'd1);
      chk("dir_imm32",   {32'b0, b32.out_imm}, {32'b0, e32});
      chk("dir_fmt32",   64'(b32.out_fmt), 64'(f32));
      chk("dir_imm64",   b64.out_imm, e64);
      chk("dir_fmt64",   64'(b64.out_fmt), 64'(f64));
      cyc(); out_ready = 1'b1;
      cyc(); out_ready = 1'b0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0]  ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F, 7'h00};
      logic [31:0] w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held: handshake outputs low.
      repeat (2) cyc();
      @(negedge clk);
      chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
      chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
      cyc(); reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);
      chk("post_rst_valid",    64'(b64.out_valid), 64'd0);
      chk("post_rst_imm",      b64.out_imm, 64'd0);
      chk("post_rst_fmt",      64'(b32.out_fmt), 64'(NONE));
      chk("post_rst_tag",      64'(b32.out_tag), 64'd0);

      directed(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 3'd1, 8'h11);
      directed(32'h123450B7, 32'h12345000, 64'h00000000_12345000, 3'd4, 3'd4, 8'h12);
      directed(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 3'd3, 8'h13);
      directed(32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 3'd6, 3'd6, 8'h14);
      directed(32'h0000007F, 32'h00000000, 64'h00000000_00000000, 3'd0, 3'd0, 8'h15);

      // Backpressure: two accepts fill the buffer, tag 3 waits.
      n_acc = 0;
      cyc(); in_valid = 1'b1; in_inst = rand_inst(); in_tag = 8'd1;
      cyc(); in_inst = rand_inst(); in_tag = 8'd2;
      cyc(); in_inst = rand_inst(); in_tag = 8'd3;
      cyc();
      @(negedge clk);
      chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
      chk("bp_accepts", 64'(n_acc), 64'd2);
      cyc(); out_ready = 1'b1;
      @(negedge clk); chk("bp_nogap0", 64'(b32.out_valid), 64'd1);
      cyc();
      @(negedge clk); chk("bp_nogap1", 64'(b32.out_valid), 64'd1);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("bp_nogap2", 64'(b32.out_valid), 64'd1);
      chk("bp_accepts3", 64'(n_acc), 64'd3);
      cyc(); out_ready = 1'b0;
      cyc();

      // Flush with a full buffer and a concurrent push attempt.
      in_valid = 1'b1; in_inst = rand_inst(); in_tag = 8'd10;
      cyc(); in_inst = rand_inst(); in_tag = 8'd11;
      cyc(); flush = 1'b1; in_inst = rand_inst(); in_tag = 8'd12;
      cyc(); flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 64'(b32.out_valid), 64'd0);
      chk("flush_in_ready", 64'(b32.in_ready), 64'd1);

      // Reset mid-stream with one entry buffered.
      cyc(); in_valid = 1'b1; in_inst = 32'h123450B7; in_tag = 8'd20;
      cyc(); in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 64'(b32.in_ready), 64'd0);
      chk("mid_rst_valid",    64'(b32.out_valid), 64'd0);
      cyc(); reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(b32.out_valid), 64'd0);
      chk("mid_rst_imm",       b64.out_imm, 64'd0);
      chk("mid_rst_fmt",       64'(b64.out_fmt), 64'(NONE));

      // Randomized traffic with occasional flushes.
      for (int k = 0; k < 400; k++) begin
         cyc();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_inst   = rand_inst();
         in_tag    = 8'($urandom);
      end
      cyc(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (6) cyc();
      @(negedge clk);
      chk("drain32", 64'(q32.size()), 64'd0);
      chk("drain64", 64'(q64.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
